// File: rtl/bridge_pkg.sv
// Types and constants shared by the AXI4-Lite frontend and the APB transactor.
package bridge_pkg;

    localparam int unsigned PROT_W = 3;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_BRESP = 3'd3,
        ST_RRESP = 3'd4
    } fe_state_e;

    // Map a transactor error flag onto the AXI response code.
    function automatic logic [RESP_W-1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4lite_hold_reg.sv
// One-entry valid/ready holding register: accepts a beat whenever empty,
// keeps it until the owner clears it.
module axi4lite_hold_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         ready_c,
    output logic         held,
    output logic [W-1:0] data
);

    assign ready_c = !held;

    // Clear wins; the owner only clears while full, so it never races a capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= 1'b0;
            data <= '0;
        end else if (clear) begin
            held <= 1'b0;
        end else if (in_valid && !held) begin
            held <= 1'b1;
            data <= in_data;
        end
    end

endmodule

// File: rtl/axi4lite_slave_frontend.sv
// AXI4-Lite slave frontend: captures AW/W/AR, arbitrates one outstanding
// command towards the APB transactor and returns the B/R response.
module axi4lite_slave_frontend
    import bridge_pkg::*;
#(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned addrWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [addrWidth-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [dataWidth-1:0]   wdata,
    input  logic [dataWidth/8-1:0] wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [addrWidth-1:0]   araddr,
    input  logic [2:0]             arprot,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [dataWidth-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_write,
    output logic [addrWidth-1:0]   cmd_addr,
    output logic [dataWidth-1:0]   cmd_wdata,
    output logic [dataWidth/8-1:0] cmd_strb,
    output logic [2:0]             cmd_prot,
    input  logic                   rsp_valid,
    input  logic                   rsp_err,
    input  logic [dataWidth-1:0]   rsp_rdata
);

    localparam int unsigned STRB_W = dataWidth / 8;
    localparam int unsigned AW_W   = addrWidth + PROT_W;
    localparam int unsigned W_W    = dataWidth + STRB_W;

    fe_state_e           state;
    fe_state_e           state_nxt;
    logic                aw_held;
    logic                w_held;
    logic [AW_W-1:0]     aw_data;
    logic [W_W-1:0]      w_data;
    logic                hold_clr;
    logic                write_pend;
    logic                contend;
    logic                grant_wr;
    logic                grant_rd;
    logic                prio_wr;

    axi4lite_hold_reg #(.W(AW_W)) u_aw_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (awvalid),
        .in_data  ({awprot, awaddr}),
        .clear    (hold_clr),
        .ready_c  (awready),
        .held     (aw_held),
        .data     (aw_data)
    );

    axi4lite_hold_reg #(.W(W_W)) u_w_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (wvalid),
        .in_data  ({wstrb, wdata}),
        .clear    (hold_clr),
        .ready_c  (wready),
        .held     (w_held),
        .data     (w_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_wr || grant_rd) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    state_nxt = cmd_write ? ST_BRESP : ST_RRESP;
                end
            end
            ST_BRESP: begin
                if (bvalid && bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RRESP: begin
                if (rvalid && rready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant decode; prio_wr picks the winner only when both sides request.
    always_comb begin
        write_pend = 1'b0;
        contend    = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        arready    = 1'b0;
        hold_clr   = 1'b0;
        if (state == ST_IDLE) begin
            write_pend = aw_held && w_held;
            contend    = write_pend && arvalid;
            grant_wr   = write_pend && (!arvalid || prio_wr);
            grant_rd   = arvalid && !grant_wr;
            arready    = grant_rd;
            hold_clr   = grant_wr;
        end
    end

    // Command register towards the transactor; fields frozen until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_wr   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_strb  <= '0;
            cmd_prot  <= '0;
        end else begin
            if (contend) begin
                prio_wr <= !prio_wr;
            end
            if (grant_wr) begin
                cmd_write <= 1'b1;
                cmd_addr  <= aw_data[addrWidth-1:0];
                cmd_prot  <= aw_data[AW_W-1 -: PROT_W];
                cmd_wdata <= w_data[dataWidth-1:0];
                cmd_strb  <= w_data[W_W-1 -: STRB_W];
            end else if (grant_rd) begin
                cmd_write <= 1'b0;
                cmd_addr  <= araddr;
                cmd_prot  <= arprot;
                cmd_wdata <= '0;
                cmd_strb  <= '0;
            end
            if (grant_wr || grant_rd) begin
                cmd_valid <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    // B/R response registers; completions outside WAIT are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid <= 1'b0;
            bresp  <= '0;
            rvalid <= 1'b0;
            rresp  <= '0;
            rdata  <= '0;
        end else begin
            if (state == ST_WAIT && rsp_valid) begin
                if (cmd_write) begin
                    bvalid <= 1'b1;
                    bresp  <= resp_code(rsp_err);
                end else begin
                    rvalid <= 1'b1;
                    rresp  <= resp_code(rsp_err);
                    rdata  <= rsp_rdata;
                end
            end else begin
                if (bvalid && bready) begin
                    bvalid <= 1'b0;
                end
                if (rvalid && rready) begin
                    rvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_frontend.sv
// Directed bench for axi4lite_slave_frontend with hand-computed expectations.
module tb_axi4lite_slave_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = !clk;

    axi4lite_slave_frontend dut (
        .clk       (clk),
        .rst       (rst),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arprot    (arprot),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle completion pulse from the transactor.
    task automatic respond(input logic err, input logic [31:0] rd);
        rsp_valid = 1'b1;
        rsp_err   = err;
        rsp_rdata = rd;
        tick();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_cmd_addr", cmd_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_wready", 32'(wready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = '0; awprot = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0; arvalid = 1'b0; araddr = '0; arprot = '0;
        rready = 1'b0; cmd_ready = 1'b1;
        rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
        do_reset();

        // Read to 0x10 with completion a few cycles after the command.
        araddr = 32'h10; arprot = 3'd2; arvalid = 1'b1;
        #1;
        chk("s1_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("s1_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("s1_cmd_write", 32'(cmd_write), 32'd0);
        chk("s1_cmd_strb", 32'(cmd_strb), 32'd0);
        chk("s1_cmd_addr", cmd_addr, 32'h10);
        chk("s1_cmd_prot", 32'(cmd_prot), 32'd2);
        tick();
        chk("s1_cmd_drop", 32'(cmd_valid), 32'd0);
        repeat (2) tick();
        chk("s1_rvalid_early", 32'(rvalid), 32'd0);
        respond(1'b0, 32'hDEAD_BEEF);
        chk("s1_rvalid", 32'(rvalid), 32'd1);
        chk("s1_rdata", rdata, 32'hDEAD_BEEF);
        chk("s1_rresp", 32'(rresp), 32'd0);
        tick();
        chk("s1_rvalid_hold", 32'(rvalid), 32'd1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("s1_rvalid_done", 32'(rvalid), 32'd0);

        // W two cycles ahead of AW.
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        chk("s2_wready_pre", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
        chk("s2_wready_held", 32'(wready), 32'd0);
        repeat (2) tick();
        chk("s2_no_cmd", 32'(cmd_valid), 32'd0);
        awaddr = 32'h20; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("s2_awready_held", 32'(awready), 32'd0);
        chk("s2_no_cmd_yet", 32'(cmd_valid), 32'd0);
        tick();
        chk("s2_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("s2_cmd_write", 32'(cmd_write), 32'd1);
        chk("s2_cmd_addr", cmd_addr, 32'h20);
        chk("s2_cmd_wdata", cmd_wdata, 32'h1234_5678);
        chk("s2_cmd_strb", 32'(cmd_strb), 32'hF);
        chk("s2_awready_back", 32'(awready), 32'd1);
        chk("s2_wready_back", 32'(wready), 32'd1);
        tick();
        respond(1'b0, 32'h0);
        chk("s2_bvalid", 32'(bvalid), 32'd1);
        chk("s2_bresp", 32'(bresp), 32'd0);
        chk("s2_rdata_kept", rdata, 32'hDEAD_BEEF);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("s2_bvalid_done", 32'(bvalid), 32'd0);

        // Write with SLVERR and bready held low for four cycles.
        awaddr = 32'h30; awvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("s3_cmd_valid", 32'(cmd_valid), 32'd1);
        tick();
        respond(1'b1, 32'h0);
        arvalid = 1'b1; araddr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("s3_bvalid_%0d", i), 32'(bvalid), 32'd1);
            chk($sformatf("s3_bresp_%0d", i), 32'(bresp), 32'd2);
            chk($sformatf("s3_arready_%0d", i), 32'(arready), 32'd0);
            tick();
        end
        arvalid = 1'b0; bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("s3_bvalid_done", 32'(bvalid), 32'd0);

        // Contended grants: read first after reset, then write, then read.
        do_reset();
        awaddr = 32'h50; awvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h60;
        #1;
        chk("s4_rd_first", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("s4_cmd1_write", 32'(cmd_write), 32'd0);
        chk("s4_cmd1_addr", cmd_addr, 32'h60);
        tick();
        respond(1'b0, 32'h600D_0001);
        chk("s4_rdata1", rdata, 32'h600D_0001);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h70;
        #1;
        chk("s4_wr_second", 32'(arready), 32'd0);
        tick();
        chk("s4_cmd2_write", 32'(cmd_write), 32'd1);
        chk("s4_cmd2_addr", cmd_addr, 32'h50);
        chk("s4_cmd2_wdata", cmd_wdata, 32'h1111_2222);
        awaddr = 32'h80; awvalid = 1'b1; wdata = 32'h3333_4444; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("s4_aw_refill", 32'(awready), 32'd0);
        chk("s4_w_refill", 32'(wready), 32'd0);
        respond(1'b0, 32'h0);
        chk("s4_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        #1;
        chk("s4_rd_third", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("s4_cmd3_addr", cmd_addr, 32'h70);
        tick();
        respond(1'b0, 32'h600D_0002);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("s4_rdata2", rdata, 32'h600D_0002);
        tick();
        chk("s4_cmd4_addr", cmd_addr, 32'h80);
        chk("s4_cmd4_wdata", cmd_wdata, 32'h3333_4444);
        tick();
        respond(1'b0, 32'h0);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Command stalled five cycles while new AW/W fill the holders.
        cmd_ready = 1'b0;
        awaddr = 32'h90; awprot = 3'd1; awvalid = 1'b1;
        wdata = 32'hCAFE_F00D; wstrb = 4'hC; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s5_valid_%0d", i), 32'(cmd_valid), 32'd1);
            chk($sformatf("s5_addr_%0d", i), cmd_addr, 32'h90);
            chk($sformatf("s5_wdata_%0d", i), cmd_wdata, 32'hCAFE_F00D);
            chk($sformatf("s5_strb_%0d", i), 32'(cmd_strb), 32'hC);
            chk($sformatf("s5_prot_%0d", i), 32'(cmd_prot), 32'd1);
            if (i == 0) begin
                awaddr = 32'hA0; awprot = 3'd0; awvalid = 1'b1;
                wdata = 32'h0BAD_C0DE; wstrb = 4'h1; wvalid = 1'b1;
            end else begin
                awvalid = 1'b0; wvalid = 1'b0;
            end
            tick();
        end
        chk("s5_aw_taken", 32'(awready), 32'd0);
        chk("s5_w_taken", 32'(wready), 32'd0);
        cmd_ready = 1'b1;
        tick();
        chk("s5_cmd_drop", 32'(cmd_valid), 32'd0);
        respond(1'b0, 32'h0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        tick();
        chk("s5_next_addr", cmd_addr, 32'hA0);
        chk("s5_next_wdata", cmd_wdata, 32'h0BAD_C0DE);
        chk("s5_next_strb", 32'(cmd_strb), 32'h1);
        tick();

        // Reset while waiting for the completion.
        #1;
        rst = 1'b1;
        #1;
        chk("s6_cmd_addr", cmd_addr, 32'd0);
        chk("s6_cmd_wdata", cmd_wdata, 32'd0);
        chk("s6_cmd_write", 32'(cmd_write), 32'd0);
        chk("s6_cmd_strb", 32'(cmd_strb), 32'd0);
        chk("s6_rdata", rdata, 32'd0);
        tick();
        rst = 1'b0;
        respond(1'b0, 32'h1);
        chk("s6_no_bvalid", 32'(bvalid), 32'd0);
        chk("s6_no_rvalid", 32'(rvalid), 32'd0);
        tick();
        chk("s6_no_bvalid2", 32'(bvalid), 32'd0);
        chk("s6_awready", 32'(awready), 32'd1);
        chk("s6_wready", 32'(wready), 32'd1);
        chk("s6_arready", 32'(arready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi4lite_slave_frontend.md
AXI4LITE_SLAVE_FRONTEND -- requirements
Module: axi4lite_slave_frontend

Interface
REQ-001 Parameters SHALL be: dataWidth, default 32, data bus width; addrWidth, default 32, address width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-003 Ports SHALL be as follows:
clk  in  1  clock
rst  in  1  async active-high reset
awvalid/awready  in/out  1/1  AXI write-address handshake
awaddr  in  addrWidth  write address
awprot  in  3  write protection
wvalid/wready  in/out  1/1  AXI write-data handshake
wdata  in  dataWidth  write data
wstrb  in  dataWidth/8  byte strobes
bvalid/bready  out/in  1/1  write-response handshake
bresp  out  2  write response
arvalid/arready  in/out  1/1  read-address handshake
araddr  in  addrWidth  read address
arprot  in  3  read protection
rvalid/rready  out/in  1/1  read-data handshake
rdata  out  dataWidth  read data
rresp  out  2  read response
cmd_valid/cmd_ready  out/in  1/1  command handshake to the APB transactor
cmd_write  out  1  1 = write
cmd_addr  out  addrWidth  command address
cmd_wdata  out  dataWidth  command write data
cmd_strb  out  dataWidth/8  command strobes (0 for reads)
cmd_prot  out  3  command protection
rsp_valid  in  1  one-cycle completion pulse from the transactor
rsp_err  in  1  completion error (pslverr)
rsp_rdata  in  dataWidth  read data returned by the transactor

Function
REQ-004 AW and W SHALL be captured independently into one-entry holding registers: awready = !aw_held, wready = !w_held, in any FSM state.
REQ-005 The FSM SHALL have states IDLE, CMD, WAIT, BRESP and RRESP, with one outstanding transaction at a time.
REQ-006 In IDLE, write_pend = aw_held && w_held; arready SHALL be 1 only in IDLE when the read is granted.
REQ-007 Arbitration in IDLE SHALL work as follows: only write_pend means grant write; only arvalid means grant read; both means grant per the prio flag, which toggles after each contended grant (reset = read first).
REQ-008 On grant, the block SHALL register the cmd_* fields, enter CMD, and raise cmd_valid in the next cycle (AR handshake cycle N gives cmd_valid at N+1).
REQ-009 A write grant SHALL clear both holders on the same edge, so awready and wready return to 1 in the next cycle.
REQ-010 In CMD, cmd_valid and all cmd_* fields SHALL stay stable until cmd_valid && cmd_ready, then the FSM enters WAIT.
REQ-011 In WAIT, on rsp_valid the block SHALL go to BRESP (write) or RRESP (read); bvalid/rvalid SHALL assert at the next cycle.
REQ-012 Response coding SHALL be: rsp_err=0 gives 2'b00 OKAY; rsp_err=1 gives 2'b10 SLVERR.
REQ-013 rdata SHALL latch rsp_rdata on a read completion and hold it until the next read completion.
REQ-014 bvalid/rvalid SHALL hold, with stable payload, until bready/rready, then the FSM returns to IDLE; bready or rready already high gives a 1-cycle response.
REQ-015 rsp_valid SHALL be ignored outside WAIT.
REQ-016 A new grant SHALL be possible in the cycle after the B/R handshake.

Reset
REQ-017 While rst is asserted the following SHALL hold immediately and asynchronously: state = IDLE; aw_held = w_held = 0; prio = read-first; cmd_valid, bvalid and rvalid = 0; bresp, rresp, rdata and all cmd_* = 0.
REQ-018 After reset release, awready = wready = 1 and arready follows REQ-006.
REQ-019 Reset mid-transaction SHALL drop the transaction with no B/R response; downstream recovery is the transactor's own reset.

Structure
REQ-020 A shared package bridge_pkg SHALL hold the frontend state enum and the RESP_OKAY/RESP_SLVERR constants, and SHALL be shared with the APB transactor.
REQ-021 The sub-module axi4lite_hold_reg SHALL be the one-entry valid/ready holding register, instantiated for AW and for W.

Verification
REQ-022 Scenario: read to 0x0000_0010, cmd_ready=1, rsp_valid at 3 cycles with rsp_rdata=0xDEAD_BEEF, rsp_err=0 -> cmd_write=0, cmd_strb=0, rvalid the cycle after rsp_valid, rdata=0xDEADBEEF, rresp=00.
REQ-023 Scenario: W (0x1234_5678, wstrb=0xF) two cycles before AW (0x20) -> wready low after the W handshake, cmd issued only after AW captured, cmd_addr=0x20, cmd_wdata=0x12345678, cmd_strb=0xF.
REQ-024 Scenario: write with rsp_err=1, bready held low 4 cycles -> bresp=10, bvalid stable for 4 cycles, arready=0 throughout.
REQ-025 Scenario: write_pend and arvalid in the same cycle, twice in a row after reset -> read granted first, write second, prio alternates.
REQ-026 Scenario: cmd_ready low for 5 cycles -> cmd_* fields unchanged; new AW/W are accepted into the holders while the current command is outstanding.
REQ-027 Scenario: rst asserted in WAIT -> all outputs zero the same cycle, no bvalid/rvalid afterward, awready=wready=1 after release.
